// File: rtl/exec_ctrl.sv
// Execution sequencer: single-step, free-run with gap, PC breakpoint halt, fetch wait.
// Optional retired-instruction counter enabled by defining EXEC_CTRL_ICOUNT_EN.
module exec_ctrl #(
  parameter int unsigned FETCH_LAT = 1,
  parameter int unsigned RUN_DIV   = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        step_req,
  input  logic        run_toggle,
  input  logic        halt_req,
  input  logic [31:0] pc,
  input  logic [31:0] bp_addr,
  input  logic        bp_en,
  output logic        commit,
  output logic        running,
  output logic        bp_hit,
  output logic [1:0]  state
`ifdef EXEC_CTRL_ICOUNT_EN
  ,
  input  logic        cnt_clr,
  output logic [31:0] instret
`endif
);

  typedef enum logic [1:0] {
    S_HALT   = 2'b00,
    S_WAIT   = 2'b01,
    S_COMMIT = 2'b10
  } state_t;

  // Counter holds N-1 so the WAIT exit happens when it reaches zero.
  localparam logic [23:0] STEP_LOAD = 24'(FETCH_LAT - 1);
  localparam logic [23:0] RUN_LOAD  = 24'(FETCH_LAT + RUN_DIV - 1);

  state_t      state_q, state_n;
  logic [23:0] cnt_q, cnt_n;
  logic        running_n, bp_hit_n, stop;

  assign state = state_q;

  always_comb begin
    state_n   = state_q;
    cnt_n     = cnt_q;
    running_n = running;
    bp_hit_n  = bp_hit;
    stop      = running & (run_toggle | halt_req);
    case (state_q)
      S_HALT: begin
        if (run_toggle) begin
          running_n = 1'b1;
          bp_hit_n  = 1'b0;
          state_n   = S_COMMIT;
        end else if (step_req) begin
          bp_hit_n  = 1'b0;
          state_n   = S_COMMIT;
        end
      end
      S_COMMIT: begin
        state_n = S_WAIT;
        cnt_n   = running ? RUN_LOAD : STEP_LOAD;
        if (stop) running_n = 1'b0;
      end
      S_WAIT: begin
        if (stop) running_n = 1'b0;
        if (cnt_q == 24'd0) begin
          // A stop arriving on the final wait cycle still prevents the next commit.
          if (!running || stop) begin
            running_n = 1'b0;
            state_n   = S_HALT;
          end else if (bp_en && (pc == bp_addr)) begin
            running_n = 1'b0;
            bp_hit_n  = 1'b1;
            state_n   = S_HALT;
          end else begin
            state_n   = S_COMMIT;
          end
        end else begin
          cnt_n = cnt_q - 24'd1;
        end
      end
      default: begin
        running_n = 1'b0;
        state_n   = S_HALT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_WAIT;
      cnt_q   <= STEP_LOAD;
      commit  <= 1'b0;
      running <= 1'b0;
      bp_hit  <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      commit  <= (state_n == S_COMMIT);
      running <= running_n;
      bp_hit  <= bp_hit_n;
    end
  end

`ifdef EXEC_CTRL_ICOUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          instret <= 32'd0;
    else if (cnt_clr) instret <= 32'd0;
    else if (commit)  instret <= instret + 32'd1;
  end
`endif

endmodule

// File: tb/tb_exec_ctrl.sv
// Directed bench for exec_ctrl with FETCH_LAT=1, RUN_DIV=2; pc model adds 4 per commit.
module tb_exec_ctrl;
  logic        clk = 1'b0, rst = 1'b1;
  logic        step_req = 1'b0, run_toggle = 1'b0, halt_req = 1'b0;
  logic        bp_en = 1'b0, pc_ld = 1'b0;
  logic [31:0] pc = 32'd0, bp_addr = 32'd0;
  logic        commit, running, bp_hit;
  logic [1:0]  state;
`ifdef EXEC_CTRL_ICOUNT_EN
  logic        cnt_clr = 1'b0;
  logic [31:0] instret;
`endif
  int vecs = 0, errs = 0;

  exec_ctrl #(.FETCH_LAT(1), .RUN_DIV(2)) dut (
    .clk(clk), .rst(rst), .step_req(step_req), .run_toggle(run_toggle),
    .halt_req(halt_req), .pc(pc), .bp_addr(bp_addr), .bp_en(bp_en),
    .commit(commit), .running(running), .bp_hit(bp_hit), .state(state)
`ifdef EXEC_CTRL_ICOUNT_EN
    , .cnt_clr(cnt_clr), .instret(instret)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (pc_ld) pc <= 32'd0;
    else if (commit) pc <= pc + 32'd4;

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic pc_zero;
    pc_ld = 1'b1; tick; pc_ld = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) begin
      tick;
      vecs++; if ({commit, running} !== 2'b00) begin errs++; $display("FAIL rst_hold: commit/running got %b want 00", {commit, running}); end
    end
    rst = 1'b0; #1;
    vecs++; if (state !== 2'b01) begin errs++; $display("FAIL rst_wait: state got %b want 01", state); end
    tick;
    vecs++; if (state !== 2'b00 || commit !== 1'b0) begin errs++; $display("FAIL rst_halt: state/commit got %b/%b want 00/0", state, commit); end
    step_req = 1'b1; tick; step_req = 1'b0;
    vecs++; if (commit !== 1'b1) begin errs++; $display("FAIL rst_pre_commit: got %b want 1", commit); end
    rst = 1'b1; #1;
    vecs++; if (commit !== 1'b0 || state !== 2'b01) begin errs++; $display("FAIL rst_async: commit/state got %b/%b want 0/01", commit, state); end
    tick; rst = 1'b0; tick;
    vecs++; if (state !== 2'b00) begin errs++; $display("FAIL rst_rehalt: state got %b want 00", state); end
  endtask

  task automatic test_step;
    pc_zero;
    step_req = 1'b1;
    vecs++; if (commit !== 1'b0) begin errs++; $display("FAIL step_t: commit got %b want 0", commit); end
    tick; step_req = 1'b0;
    vecs++; if (commit !== 1'b1) begin errs++; $display("FAIL step_t1: commit got %b want 1", commit); end
    tick;
    vecs++; if (state !== 2'b01 || commit !== 1'b0) begin errs++; $display("FAIL step_t2: state/commit got %b/%b want 01/0", state, commit); end
    step_req = 1'b1; tick; step_req = 1'b0;
    vecs++; if (state !== 2'b00 || commit !== 1'b0) begin errs++; $display("FAIL step_t3: state/commit got %b/%b want 00/0", state, commit); end
    tick;
    vecs++; if (commit !== 1'b0 || pc !== 32'd4) begin errs++; $display("FAIL step_drop: commit/pc got %b/%h want 0/4", commit, pc); end
  endtask

  task automatic test_run;
    int n = 0, last = 0, extra = 0;
    pc_zero;
    run_toggle = 1'b1; tick; run_toggle = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      if (commit) begin
        n++;
        if (n > 1) begin
          vecs++; if (i - last != 4) begin errs++; $display("FAIL run_spacing: got %0d want 4", i - last); end
        end
        last = i;
      end
      if (i < 20) tick;
    end
    vecs++; if (n != 5 || pc !== 32'h14) begin errs++; $display("FAIL run_count: commits/pc got %0d/%h want 5/14", n, pc); end
    halt_req = 1'b1; tick; halt_req = 1'b0;
    vecs++; if (running !== 1'b0) begin errs++; $display("FAIL run_halt: running got %b want 0", running); end
    repeat (8) begin if (commit) extra++; tick; end
    vecs++; if (extra != 0 || state !== 2'b00) begin errs++; $display("FAIL run_stop: extra commits/state got %0d/%b want 0/00", extra, state); end
  endtask

  task automatic test_breakpoint;
    logic [31:0] cpc [4];
    logic [31:0] want [4];
    int n = 0, w = 0;
    want[0] = 32'h0; want[1] = 32'h4; want[2] = 32'h8; want[3] = 32'hC;
    pc_zero;
    bp_addr = 32'h10; bp_en = 1'b1;
    run_toggle = 1'b1; tick; run_toggle = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (commit) begin
        if (n < 4) cpc[n] = pc;
        n++;
      end
      if (state == 2'b00) break;
      tick;
    end
    vecs++; if (n != 4) begin errs++; $display("FAIL bp_count: commits got %0d want 4", n); end
    for (int k = 0; k < 4 && k < n; k++) begin
      vecs++; if (cpc[k] !== want[k]) begin errs++; $display("FAIL bp_pc%0d: got %h want %h", k, cpc[k], want[k]); end
    end
    vecs++; if ({state, running, bp_hit} !== 4'b0001 || pc !== 32'h10) begin errs++; $display("FAIL bp_stop: state/run/hit/pc got %b/%b/%b/%h want 00/0/1/10", state, running, bp_hit, pc); end
    run_toggle = 1'b1; tick; run_toggle = 1'b0;
    vecs++; if ({commit, bp_hit, running} !== 3'b101 || pc !== 32'h10) begin errs++; $display("FAIL bp_resume: commit/hit/run/pc got %b/%b/%b/%h want 1/0/1/10", commit, bp_hit, running, pc); end
    repeat (4) tick;
    vecs++; if (commit !== 1'b1 || pc !== 32'h14) begin errs++; $display("FAIL bp_continue: commit/pc got %b/%h want 1/14", commit, pc); end
    halt_req = 1'b1; tick; halt_req = 1'b0;
    while (state != 2'b00 && w < 10) begin tick; w++; end
    vecs++; if (state !== 2'b00) begin errs++; $display("FAIL bp_cleanup: state got %b want 00", state); end
    bp_en = 1'b0;
  endtask

  task automatic test_simul;
    int extra = 0;
    step_req = 1'b1; run_toggle = 1'b1; tick; step_req = 1'b0; run_toggle = 1'b0;
    vecs++; if ({running, commit} !== 2'b11) begin errs++; $display("FAIL sim_both: running/commit got %b want 11", {running, commit}); end
    tick;
    vecs++; if (state !== 2'b01) begin errs++; $display("FAIL sim_wait: state got %b want 01", state); end
    run_toggle = 1'b1; tick; run_toggle = 1'b0;
    vecs++; if (running !== 1'b0) begin errs++; $display("FAIL sim_toggle: running got %b want 0", running); end
    repeat (6) begin if (commit) extra++; tick; end
    vecs++; if (extra != 0 || state !== 2'b00) begin errs++; $display("FAIL sim_stop: extra commits/state got %0d/%b want 0/00", extra, state); end
  endtask

`ifdef EXEC_CTRL_ICOUNT_EN
  task automatic test_icount;
    cnt_clr = 1'b1; tick; cnt_clr = 1'b0;
    repeat (7) begin step_req = 1'b1; tick; step_req = 1'b0; tick; tick; end
    vecs++; if (instret !== 32'd7) begin errs++; $display("FAIL ic_seven: got %0d want 7", instret); end
    step_req = 1'b1; tick; step_req = 1'b0;
    cnt_clr = 1'b1; tick; cnt_clr = 1'b0;
    vecs++; if (instret !== 32'd0) begin errs++; $display("FAIL ic_clr: got %0d want 0", instret); end
    tick;
    #1 force dut.instret = 32'hFFFF_FFFF;
    #1 release dut.instret;
    step_req = 1'b1; tick; step_req = 1'b0; tick;
    vecs++; if (instret !== 32'd0) begin errs++; $display("FAIL ic_wrap: got %h want 0", instret); end
    tick;
  endtask
`endif

  initial begin
    test_reset;
    test_step;
    test_run;
    test_breakpoint;
    test_simul;
`ifdef EXEC_CTRL_ICOUNT_EN
    test_icount;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
